// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bundle between the line receiver and its consumer.
interface deserializer_if #(
   parameter int DATA_WIDTH = 10
);
   logic [1:0]            trans_state;
   logic                  ser_in;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] parallel_out;
   logic                  out_valid;
   logic                  overrun;
   logic [1:0]            line_state;

   modport slave (
      input  trans_state,
      input  ser_in,
      input  out_ready,
      output parallel_out,
      output out_valid,
      output overrun,
      output line_state
   );

   modport master (
      output trans_state,
      output ser_in,
      output out_ready,
      input  parallel_out,
      input  out_valid,
      input  overrun,
      input  line_state
   );
endinterface

// File: rtl/deserializer.sv
// Recovers LSB-first symbols framed by the serializer's delayed transmit state
// and tracks line state from runs of equal bits outside START.
module deserializer #(
   parameter int DATA_WIDTH  = 10,
   parameter int IDLE_THRESH = 4
) (
   input logic         clk,
   input logic         rst,
   deserializer_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   localparam logic [3:0]    THR  = 4'(IDLE_THRESH);
   localparam logic [1:0]    TS_START = 2'd2;

   typedef enum logic [1:0] {
      LS_DISC   = 2'd0,
      LS_IDLE   = 2'd1,
      LS_ACTIVE = 2'd2
   } line_t;

   logic [1:0]            trans_d;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-2:0] shift_q;
   logic [DATA_WIDTH-1:0] sym;
   logic                  start;
   logic                  done;
   logic                  accept;

   line_t      ls, ls_n;
   logic [3:0] ones, ones_n;
   logic [3:0] zeros, zeros_n;

   assign start  = (trans_d == TS_START);
   assign done   = start && (bit_cnt == LAST);
   assign accept = bus.out_valid && bus.out_ready;
   // Only the upper bits are kept: bit 0 would shift out before use.
   assign sym    = {bus.ser_in, shift_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         trans_d          <= '0;
         bit_cnt          <= '0;
         shift_q          <= '0;
         bus.parallel_out <= '0;
         bus.out_valid    <= 1'b0;
         bus.overrun      <= 1'b0;
      end else begin
         trans_d <= bus.trans_state;
         if (start) begin
            shift_q <= sym[DATA_WIDTH-1:1];
            bit_cnt <= done ? '0 : bit_cnt + 1'b1;
         end else begin
            bit_cnt <= '0;
         end
         if (done) begin
            if (!bus.out_valid || bus.out_ready) begin
               bus.parallel_out <= sym;
               bus.out_valid    <= 1'b1;
            end else begin
               bus.overrun <= 1'b1;
            end
         end else if (accept) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ls    <= LS_DISC;
         ones  <= '0;
         zeros <= '0;
      end else begin
         ls    <= ls_n;
         ones  <= ones_n;
         zeros <= zeros_n;
      end
   end

   always_comb begin
      ls_n    = ls;
      ones_n  = ones;
      zeros_n = zeros;
      if (start) begin
         ls_n    = LS_ACTIVE;
         ones_n  = '0;
         zeros_n = '0;
      end else begin
         if (bus.ser_in) begin
            zeros_n = '0;
            if (ones != THR) ones_n = ones + 4'd1;
         end else begin
            ones_n = '0;
            if (zeros != THR) zeros_n = zeros + 4'd1;
         end
         if (ones_n == THR)
            ls_n = LS_IDLE;
         else if (zeros_n == THR)
            ls_n = LS_DISC;
      end
   end

   assign bus.line_state = ls;
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: scoreboard queue drained by an
// independent monitor, plus direct checks of flags and line state.
module tb_deserializer;
   localparam int W = 10;
   localparam logic [1:0] T_IDLE  = 2'd1;
   localparam logic [1:0] T_START = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   deserializer_if #(.DATA_WIDTH(W)) bus ();

   deserializer #(
      .DATA_WIDTH (W),
      .IDLE_THRESH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;
   logic [W-1:0] exp_q[$];
   int           pop_cyc[$];
   logic         nb = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ser_in lags trans_state by one cycle: the bit chosen now goes out next cycle.
   task automatic step(input logic [1:0] ts, input logic b);
      @(posedge clk);
      #1;
      bus.trans_state = ts;
      bus.ser_in      = nb;
      nb              = b;
   endtask

   task automatic send(input logic [W-1:0] s);
      for (int i = 0; i < W; i++) step(T_START, s[i]);
   endtask

   task automatic lbit(input logic b);
      bus.ser_in = b;
      nb         = b;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(T_IDLE, 1'b1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(T_IDLE, 1'b1);
      step(T_IDLE, 1'b1);
      chk("rst_pout", 32'(bus.parallel_out), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_overrun", 32'(bus.overrun), 32'd0);
      chk("rst_line", 32'(bus.line_state), 32'd0);
      rst = 1'b0;
   endtask

   // Monitor: every handshake must match the oldest expected symbol.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errs++;
               $display("FAIL unexpected_out: got %0h expected none",
                        bus.parallel_out);
            end else begin
               e = exp_q.pop_front();
               pop_cyc.push_back(cyc);
               if (bus.parallel_out !== e) begin
                  errs++;
                  $display("FAIL sb_symbol: got %0h expected %0h",
                           bus.parallel_out, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] s;
      bus.trans_state = T_IDLE;
      bus.ser_in      = 1'b1;
      bus.out_ready   = 1'b1;
      do_reset();

      // Back-to-back symbols with exact latency and spacing
      pop_cyc.delete();
      exp_q.push_back(10'h2A5);
      exp_q.push_back(10'h15A);
      send(10'h2A5);
      s = 10'h15A;
      step(T_START, s[0]);
      chk("b2b_pre_valid", 32'(bus.out_valid), 32'd0);
      step(T_START, s[1]);
      chk("b2b_lat_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_lat_data", 32'(bus.parallel_out), 32'h2A5);
      for (int i = 2; i < W; i++) step(T_START, s[i]);
      drain();
      chk("b2b_pops", 32'(pop_cyc.size()), 32'd2);
      if (pop_cyc.size() == 2)
         chk("b2b_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd10);
      chk("b2b_overrun", 32'(bus.overrun), 32'd0);

      // Abort after 6 bits, then a clean symbol
      s = 10'h2CC;
      for (int i = 0; i < 6; i++) step(T_START, s[i]);
      for (int i = 0; i < 4; i++) step(T_IDLE, 1'b1);
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      exp_q.push_back(10'h155);
      send(10'h155);
      step(T_IDLE, 1'b1);
      drain();

      // Accept of held symbol on the completion cycle of the next one
      bus.out_ready = 1'b0;
      exp_q.push_back(10'h00F);
      exp_q.push_back(10'h0F0);
      send(10'h00F);
      send(10'h0F0);
      step(T_IDLE, 1'b1);
      bus.out_ready = 1'b1;
      step(T_IDLE, 1'b1);
      bus.out_ready = 1'b0;
      chk("sim_valid", 32'(bus.out_valid), 32'd1);
      chk("sim_data", 32'(bus.parallel_out), 32'h0F0);
      chk("sim_overrun", 32'(bus.overrun), 32'd0);
      bus.out_ready = 1'b1;
      drain();

      // Line state from runs of equal bits
      for (int i = 0; i < 4; i++) lbit(1'b0);
      chk("ls_disc", 32'(bus.line_state), 32'd0);
      for (int i = 0; i < 3; i++) lbit(1'b1);
      chk("ls_ones3", 32'(bus.line_state), 32'd0);
      lbit(1'b1);
      chk("ls_idle", 32'(bus.line_state), 32'd1);
      for (int i = 0; i < 3; i++) lbit(1'b0);
      chk("ls_zeros3", 32'(bus.line_state), 32'd1);
      lbit(1'b0);
      chk("ls_disc4", 32'(bus.line_state), 32'd0);
      step(T_START, 1'b0);
      step(T_START, 1'b0);
      chk("ls_hold", 32'(bus.line_state), 32'd0);
      step(T_IDLE, 1'b0);
      chk("ls_active", 32'(bus.line_state), 32'd2);
      step(T_IDLE, 1'b1);
      step(T_IDLE, 1'b1);

      // Backpressure drops the second symbol and sets overrun
      bus.out_ready = 1'b0;
      send(10'h001);
      send(10'h3FF);
      step(T_IDLE, 1'b1);
      step(T_IDLE, 1'b1);
      chk("bp_data", 32'(bus.parallel_out), 32'h001);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_overrun", 32'(bus.overrun), 32'd1);

      // Reset mid-symbol discards held and partial symbols
      s = 10'h3C3;
      for (int i = 0; i < 6; i++) step(T_START, s[i]);
      rst = 1'b1;
      step(T_IDLE, 1'b1);
      chk("mrst_pout", 32'(bus.parallel_out), 32'd0);
      chk("mrst_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_overrun", 32'(bus.overrun), 32'd0);
      chk("mrst_line", 32'(bus.line_state), 32'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step(T_IDLE, 1'b1);
      exp_q.push_back(10'h3C3);
      send(10'h3C3);
      step(T_IDLE, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter DATA_WIDTH, default 10, SHALL set the symbol width in bits.
REQ-002 Parameter IDLE_THRESH, default 4, SHALL set the consecutive equal-bit count for line-state detection; legal range 2..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 trans_state  input  2  transmit-FSM state feeding the upstream serializer: 0 DISCONNECTED, 1 IDLE, 2 START, 3 reserved.
REQ-006 ser_in  input  1  serial bit stream, LSB of each symbol first, lagging trans_state by one cycle.
REQ-007 out_ready  input  1  consumer accepts the held symbol when high with out_valid.
REQ-008 parallel_out  output  DATA_WIDTH  recovered symbol.
REQ-009 out_valid  output  1  parallel_out holds an unconsumed symbol.
REQ-010 overrun  output  1  sticky flag: a completed symbol was dropped.
REQ-011 line_state  output  2  0 DISCONNECTED, 1 IDLE, 2 ACTIVE; 3 SHALL never be driven.

Function
REQ-012 trans_d SHALL be trans_state registered once; all framing SHALL use trans_d so it aligns with ser_in.
REQ-013 While trans_d==START, each cycle SHALL shift: shift_reg <= {ser_in, shift_reg[DATA_WIDTH-1:1]}, with bit_cnt incrementing 0..DATA_WIDTH-1.
REQ-014 On the cycle bit_cnt==DATA_WIDTH-1 (completion), the symbol {ser_in, shift_reg[DATA_WIDTH-1:1]} SHALL be presented, bit_cnt SHALL wrap to 0, and reception SHALL continue on the next bit without a gap.
REQ-015 Latency: the symbol SHALL appear on parallel_out with out_valid=1 on the first cycle after its last bit is sampled.
REQ-016 Handshake: out_valid SHALL clear after a cycle with out_valid && out_ready, unless a completion occurs on that same cycle.
REQ-017 Completion with out_valid=0, or with out_valid && out_ready, SHALL load the new symbol; out_valid SHALL be 1 afterwards.
REQ-018 Completion with out_valid && !out_ready SHALL drop the new symbol, keep parallel_out unchanged, and set overrun=1 until reset.
REQ-019 parallel_out SHALL be stable while out_valid=1 and not accepted.
REQ-020 If trans_d leaves START mid-symbol, bit_cnt SHALL reset to 0, the partial symbol SHALL be discarded, and out_valid SHALL not assert for it.
REQ-021 trans_d==3 SHALL be treated as not-START: no shifting, bit_cnt cleared.
REQ-022 Line-state FSM: any cycle with trans_d==START SHALL move to ACTIVE and clear the run counters.
REQ-023 With trans_d!=START, run counters SHALL count consecutive 1s and consecutive 0s on ser_in; each clears when the opposite bit arrives, saturating at IDLE_THRESH.
REQ-024 A ones-run reaching IDLE_THRESH SHALL set line_state IDLE; a zeros-run reaching IDLE_THRESH SHALL set DISCONNECTED; otherwise line_state SHALL hold.
REQ-025 The line-state FSM SHALL be independent of the out_valid/out_ready handshake.

Reset
REQ-026 With rst high at a clock edge, the following SHALL be cleared: parallel_out=0, out_valid=0, overrun=0, line_state=DISCONNECTED, trans_d=0, bit_cnt=0, shift_reg=0, run counters=0.
REQ-027 Reset asserted mid-symbol SHALL discard the partial symbol and any held symbol; reception SHALL restart at bit 0 on the first START cycle after release.

Verification
REQ-028 Back-to-back symbols: with trans_state=START and 10'h2A5 then 10'h15A sent LSB-first, out_ready=1 -> parallel_out=10'h2A5 one cycle after bit 9, then 10'h15A exactly 10 cycles later; overrun=0.
REQ-029 Backpressure: out_ready=0 across two symbols 10'h001 then 10'h3FF -> parallel_out holds 10'h001, out_valid=1, overrun=1 after the second completion.
REQ-030 Simultaneous accept and completion: out_ready pulses on the completion cycle of symbol 10'h0F0 while 10'h00F is held -> parallel_out=10'h0F0, out_valid stays 1, overrun=0.
REQ-031 Abort: trans_state drops to IDLE after 6 bits -> no out_valid; the next START with 10'h155 yields 10'h155.
REQ-032 Line state: trans_d=IDLE with ser_in=1 for 4 cycles -> line_state=IDLE; then ser_in=0 for 3 cycles -> still IDLE; 4th zero -> DISCONNECTED; START -> ACTIVE next cycle.
REQ-033 Mid-symbol reset: rst high for 1 cycle at bit 5 -> all outputs at reset values; the next full symbol 10'h3C3 is recovered correctly.
